// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode/state encodings and 7-segment constants
// for the sequential signed ALU.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_AND     = 3'b010,
        OP_OR      = 3'b011,
        OP_MUL     = 3'b100,
        OP_ACC     = 3'b101,
        OP_CLR     = 3'b110,
        OP_ILLEGAL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };
    localparam logic [7:0] SEG_ERR   = 8'h80;
    localparam logic [7:0] SEG_MINUS = 8'h80;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the operand logic (master)
// and the sequential ALU (slave).
interface alu_seq_if #(parameter int NBITS = 4);
    logic             start;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [2:0]       op;
    logic [NBITS-1:0] result;
    logic             busy;
    logic             done;
    logic             error;
    logic [7:0]       seg;

    modport master (output start, a, b, op,
                    input  result, busy, done, error, seg);
    modport slave  (input  start, a, b, op,
                    output result, busy, done, error, seg);
endinterface

// File: rtl/alu_seq_seg7_signed_dec.sv
// seg7_signed_dec: signed value -> 7-segment pattern. Digits 0..9 by
// magnitude with bit7 as minus sign; anything else (or an error) shows 0x80.
module seg7_signed_dec #(parameter int NBITS = 4) (
    input  logic [NBITS-1:0] value,
    input  logic             error,
    output logic [7:0]       seg
);
    import alu_seq_pkg::*;

    logic             neg;
    logic [NBITS-1:0] mag;

    // Unsigned magnitude; the most negative value keeps its full magnitude.
    assign neg = value[NBITS-1];
    assign mag = neg ? -value : value;

    // Digit lookup with minus overlay, error pattern by default.
    always_comb begin
        seg = SEG_ERR;
        if (!error) begin
            for (int i = 0; i < 10; i++) begin
                if (32'(mag) == i) seg = SEG_DIGIT[i] | (neg ? SEG_MINUS : 8'h00);
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential signed ALU (ADD/SUB/AND/OR/MUL/ACC/CLR) with a
// busy/done handshake, overflow/illegal-op error flag and 7-segment output.
// Build option ALU_MUL_EN: when defined, opcode MUL runs an NBITS-cycle
// shift-add multiplier; when undefined, MUL is handled as an illegal op.
//
// state | meaning
// IDLE  | waiting for start, operands latched on start
// EXEC  | executing; one cycle, or NBITS cycles for MUL
// DONE  | result valid, done pulse, returns to IDLE
module alu_seq #(parameter int NBITS = 4) (
    input logic       clk_2,
    input logic       reset,
    alu_seq_if.slave  bus
);
    import alu_seq_pkg::*;

    state_t           state;
    op_t              op_q;
    logic [NBITS-1:0] a_q;
    logic [NBITS-1:0] b_q;
    logic [NBITS-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic [NBITS:0]   ext_sum;
    logic [NBITS-1:0] alu_res;
    logic             alu_err;
    logic             exec_last;
    logic [NBITS-1:0] fin_res;
    logic             fin_err;

`ifdef ALU_MUL_EN
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic [CW-1:0]      cnt_q;
    logic [2*NBITS-1:0] ma_q;
    logic [NBITS-1:0]   mb_q;
    logic [2*NBITS-1:0] acc_q;
    logic [2*NBITS-1:0] acc_next;
    logic [2*NBITS-1:0] prod;
    logic               mneg_q;
    logic               mul_err;
    logic [NBITS-1:0]   mag_a;
    logic [NBITS-1:0]   mag_b;

    assign mag_a = bus.a[NBITS-1] ? -bus.a : bus.a;
    assign mag_b = bus.b[NBITS-1] ? -bus.b : bus.b;

    // One partial product per cycle; sign and range check on the final sum.
    always_comb begin
        acc_next = acc_q + (mb_q[0] ? ma_q : '0);
        prod     = mneg_q ? -acc_next : acc_next;
        mul_err  = ~((&prod[2*NBITS-1:NBITS-1]) | ~(|prod[2*NBITS-1:NBITS-1]));
    end
`endif

    // Single-cycle ops: arithmetic at NBITS+1 bits, overflow when the top two bits differ.
    always_comb begin
        ext_sum = '0;
        alu_res = result_q;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD:  ext_sum = {a_q[NBITS-1], a_q} + {b_q[NBITS-1], b_q};
            OP_SUB:  ext_sum = {a_q[NBITS-1], a_q} - {b_q[NBITS-1], b_q};
            OP_ACC:  ext_sum = {result_q[NBITS-1], result_q} + {a_q[NBITS-1], a_q};
            default: ext_sum = '0;
        endcase
        case (op_q)
            OP_ADD, OP_SUB, OP_ACC: begin
                alu_res = ext_sum[NBITS-1:0];
                alu_err = ext_sum[NBITS] ^ ext_sum[NBITS-1];
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_CLR:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // Selects the completing datapath and whether this EXEC cycle is the last.
    always_comb begin
        exec_last = 1'b1;
        fin_res   = alu_res;
        fin_err   = alu_err;
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
            exec_last = (cnt_q == '0);
            fin_res   = prod[NBITS-1:0];
            fin_err   = mul_err;
        end
`endif
    end

    // Control FSM with registered result and handshake outputs.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef ALU_MUL_EN
            cnt_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            mneg_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        op_q   <= op_t'(bus.op);
                        busy_q <= 1'b1;
                        state  <= EXEC;
`ifdef ALU_MUL_EN
                        cnt_q  <= CW'(NBITS - 1);
                        ma_q   <= {{NBITS{1'b0}}, mag_a};
                        mb_q   <= mag_b;
                        acc_q  <= '0;
                        mneg_q <= bus.a[NBITS-1] ^ bus.b[NBITS-1];
`endif
                    end
                end
                EXEC: begin
                    if (exec_last) begin
                        result_q <= fin_res;
                        error_q  <= fin_err;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
`ifdef ALU_MUL_EN
                    else begin
                        acc_q <= acc_next;
                        ma_q  <= ma_q << 1;
                        mb_q  <= mb_q >> 1;
                        cnt_q <= cnt_q - CW'(1);
                    end
`endif
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = error_q;

    seg7_signed_dec #(.NBITS(NBITS)) u_seg (
        .value (result_q),
        .error (error_q),
        .seg   (bus.seg)
    );
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, multi-cycle corner sequences and
// randomized operations checked against an integer reference model.
module tb_alu_seq;
    localparam int N = 4;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         err;
        logic [7:0]   seg;
        int           busy;
    } vec_t;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    alu_seq_if #(.NBITS(N)) bus ();

    alu_seq #(.NBITS(N)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_2 = ~clk_2;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int sx(input logic [N-1:0] v);
        return v[N-1] ? int'(v) - (1 << N) : int'(v);
    endfunction

    // Reference: exact integer result, range-checked, low N bits kept.
    function automatic void model(input logic [2:0] op, input logic [N-1:0] a,
                                  input logic [N-1:0] b, inout logic [N-1:0] r,
                                  output logic e);
        int ex;
        bit arith;
        ex = 0;
        arith = 1'b1;
        e = 1'b0;
        case (op)
            3'd0: ex = sx(a) + sx(b);
            3'd1: ex = sx(a) - sx(b);
            3'd2: begin r = a & b; arith = 1'b0; end
            3'd3: begin r = a | b; arith = 1'b0; end
            3'd4: begin
                if (MUL_EN) ex = sx(a) * sx(b);
                else begin e = 1'b1; arith = 1'b0; end
            end
            3'd5: ex = sx(r) + sx(a);
            3'd6: begin r = '0; arith = 1'b0; end
            default: begin e = 1'b1; arith = 1'b0; end
        endcase
        if (arith) begin
            e = (ex < -(1 << (N-1))) || (ex > (1 << (N-1)) - 1);
            r = ex[N-1:0];
        end
    endfunction

    function automatic logic [7:0] seg_model(input logic [N-1:0] r, input logic e);
        logic [7:0] digits [10];
        int v;
        int m;
        digits = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        v = sx(r);
        m = (v < 0) ? -v : v;
        if (e || m > 9) return 8'h80;
        return digits[m] | ((v < 0) ? 8'h80 : 8'h00);
    endfunction

    // Issue one operation; returns busy cycles seen before done and whether done arrived.
    task automatic run_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit hold_start, output int busy_cycles, output bit got_done);
        busy_cycles = 0;
        got_done = 1'b0;
        @(negedge clk_2);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk_2);
        #1;
        if (!hold_start) bus.start = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            @(negedge clk_2);
            if (bus.done) got_done = 1'b1;
            else if (bus.busy) busy_cycles++;
        end
        bus.start = 1'b0;
        if (!got_done) check("done_timeout", 0, 1);
    endtask

    vec_t         vecs [17];
    int           bc;
    bit           gd;
    int           extra_done;
    logic [2:0]   rop;
    logic [N-1:0] ra, rb, model_r, exp_r;
    logic         exp_e;

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;

        vecs[0]  = '{3'd0, 4'd3,  4'd2, 4'd5,  1'b0, 8'h6D, 1};
        vecs[1]  = '{3'd0, 4'd7,  4'd1, 4'h8,  1'b1, 8'h80, 1};
        vecs[2]  = '{3'd2, 4'd6,  4'd3, 4'd2,  1'b0, 8'h5B, 1};
        vecs[3]  = '{3'd3, 4'd4,  4'd1, 4'd5,  1'b0, 8'h6D, 1};
        vecs[4]  = '{3'd6, 4'd5,  4'd5, 4'd0,  1'b0, 8'h3F, 1};
        vecs[5]  = '{3'd5, 4'd3,  4'd0, 4'd3,  1'b0, 8'h4F, 1};
        vecs[6]  = '{3'd5, 4'd3,  4'd0, 4'd6,  1'b0, 8'h7D, 1};
        vecs[7]  = '{3'd5, 4'd3,  4'd0, 4'h9,  1'b1, 8'h80, 1};
        vecs[8]  = '{3'd7, 4'd1,  4'd1, 4'h9,  1'b1, 8'h80, 1};
        vecs[9]  = '{3'd1, 4'hC,  4'd0, 4'hC,  1'b0, 8'hE6, 1};
        vecs[12] = '{3'd0, 4'h8,  4'h8, 4'h0,  1'b1, 8'h80, 1};
`ifdef ALU_MUL_EN
        vecs[10] = '{3'd4, 4'hE,  4'd3, 4'hA,  1'b0, 8'hFD, N};
        vecs[13] = '{3'd4, 4'h8,  4'h8, 4'h0,  1'b1, 8'h80, N};
        vecs[14] = '{3'd4, 4'h8,  4'h1, 4'h8,  1'b0, 8'hFF, N};
        vecs[15] = '{3'd4, 4'h7,  4'h7, 4'h1,  1'b1, 8'h80, N};
        vecs[16] = '{3'd4, 4'hF,  4'hF, 4'h1,  1'b0, 8'h06, N};
`else
        vecs[10] = '{3'd4, 4'hE,  4'd3, 4'hC,  1'b1, 8'h80, 1};
        vecs[13] = '{3'd4, 4'h8,  4'h8, 4'h0,  1'b1, 8'h80, 1};
        vecs[14] = '{3'd4, 4'h8,  4'h1, 4'h0,  1'b1, 8'h80, 1};
        vecs[15] = '{3'd4, 4'h7,  4'h7, 4'h0,  1'b1, 8'h80, 1};
        vecs[16] = '{3'd4, 4'hF,  4'hF, 4'h0,  1'b1, 8'h80, 1};
`endif
        vecs[11] = '{3'd1, 4'h8,  4'h1, 4'h7,  1'b1, 8'h80, 1};

        // Reset state
        repeat (3) @(posedge clk_2);
        @(negedge clk_2);
        check("rst_result", int'(bus.result), 0);
        check("rst_busy",   int'(bus.busy),   0);
        check("rst_done",   int'(bus.done),   0);
        check("rst_error",  int'(bus.error),  0);
        check("rst_seg",    int'(bus.seg),    'h3F);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, bc, gd);
            check($sformatf("vec%0d_busy", i),   bc, vecs[i].busy);
            check($sformatf("vec%0d_result", i), int'(bus.result), int'(vecs[i].res));
            check($sformatf("vec%0d_error", i),  int'(bus.error),  int'(vecs[i].err));
            check($sformatf("vec%0d_seg", i),    int'(bus.seg),    int'(vecs[i].seg));
            @(negedge clk_2);
            check($sformatf("vec%0d_done_pulse", i), int'(bus.done), 0);
        end

        // start held through busy must not launch a second ACC
        run_op(3'd6, 4'd0, 4'd0, 1'b0, bc, gd);
        run_op(3'd5, 4'd1, 4'd0, 1'b1, bc, gd);
        check("hold_result", int'(bus.result), 1);
        extra_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_2);
            if (bus.done || bus.busy) extra_done++;
        end
        check("hold_no_second_op", extra_done, 0);
        check("hold_result_after", int'(bus.result), 1);

        // Randomized operations against the reference model
        run_op(3'd6, 4'd0, 4'd0, 1'b0, bc, gd);
        model_r = '0;
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            exp_r = model_r;
            model(rop, ra, rb, exp_r, exp_e);
            run_op(rop, ra, rb, 1'b0, bc, gd);
            check($sformatf("rnd%0d_op%0d_busy", i, rop), bc, (rop == 3'd4 && MUL_EN) ? N : 1);
            check($sformatf("rnd%0d_op%0d_result", i, rop), int'(bus.result), int'(exp_r));
            check($sformatf("rnd%0d_op%0d_error", i, rop),  int'(bus.error),  int'(exp_e));
            check($sformatf("rnd%0d_op%0d_seg", i, rop),    int'(bus.seg),    int'(seg_model(exp_r, exp_e)));
            model_r = exp_r;
        end

        // Reset during the second cycle of a MUL
        run_op(3'd0, 4'd1, 4'd1, 1'b0, bc, gd);
        check("pre_rst_result", int'(bus.result), 2);
        @(negedge clk_2);
        @(negedge clk_2);
        bus.start = 1'b1;
        bus.op = 3'd4;
        bus.a = 4'hE;
        bus.b = 4'd3;
        @(posedge clk_2);
        #1;
        bus.start = 1'b0;
        @(posedge clk_2);
        @(negedge clk_2);
        reset = 1'b1;
        @(posedge clk_2);
        #1;
        reset = 1'b0;
        @(negedge clk_2);
        check("midrst_result", int'(bus.result), 0);
        check("midrst_busy",   int'(bus.busy),   0);
        check("midrst_done",   int'(bus.done),   0);
        check("midrst_error",  int'(bus.error),  0);
        check("midrst_seg",    int'(bus.seg),    'h3F);
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_2);
            if (bus.done || bus.busy) extra_done++;
        end
        check("midrst_discarded", extra_done, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential signed ALU, the successor to the board's combinational 3-bit switch ALU. It latches NBITS-wide signed operands on a start strobe and executes add, sub, and, or, accumulate, clear and a multi-cycle shift-add multiply through a small FSM. It reports the result with busy/done handshake and an error flag, and drives the signed 7-segment display. It sits between the SWI-driven operand logic in `top` and the SEG/LED outputs.

## Interface
- NBITS, 4: operand/result width, signed two's complement; legal 3..16.
- clk_2  in  1  system clock (divided board clock).
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  NBITS  signed operand A.
- b  in  NBITS  signed operand B.
- op  in  3  opcode (see Operation).
- result  out  NBITS  registered signed result; reset 0.
- busy  out  1  high while in EXEC; reset 0.
- done  out  1  one-cycle pulse while in DONE; reset 0.
- error  out  1  overflow or illegal op of last operation; reset 0.
- seg  out  8  7-segment pattern of result, bit7 = minus/error; reset 0x3F (zero).

## Operation
- Opcodes: 000 ADD r=a+b; 001 SUB r=a−b; 010 AND; 011 OR; 100 MUL r=a·b; 101 ACC r=result+a; 110 CLR r=0; 111 illegal.
- FSM states: IDLE, EXEC, DONE.
  - IDLE & start: latch a, b, op; go to EXEC.
  - IDLE & !start: stay in IDLE.
  - EXEC: single-cycle ops → DONE after 1 cycle; MUL → DONE after NBITS cycles.
  - DONE → IDLE unconditionally.
- start outside IDLE is ignored, not queued.
- Arithmetic is computed at NBITS+1 bits (MUL at 2·NBITS bits).
  - error=1 if the exact value lies outside [−2^(NBITS−1), 2^(NBITS−1)−1].
  - result always takes the low NBITS bits.
- AND/OR/CLR never overflow.
- Illegal op: result unchanged, error=1.
- error is not sticky; it is rewritten each completed operation.
- MUL: unsigned shift-add on operand magnitudes, one partial product per cycle, sign applied at the last iteration.
  - The magnitude of −2^(NBITS−1) is held in NBITS bits, with no wrap.
- seg is combinational from result and error:
  - |result| ≤ 9 and error=0: digit pattern (0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F), with bit7 set if negative.
  - Otherwise: 0x80.

## Timing
- Start is sampled at edge k.
- Single-cycle ops: result and error update at edge k+1; done=1 in cycle k+1..k+2; IDLE at edge k+2.
- MUL: busy=1 for NBITS cycles; result and error update at edge k+NBITS; done the following cycle.
- Next start is accepted on the cycle after done falls. Minimum issue interval is 3 cycles for single-cycle ops and NBITS+2 cycles for MUL.
- Reset has priority over everything, including mid-MUL:
  - next edge gives IDLE, result=0, busy=0, done=0, error=0;
  - the partial product is discarded.
- ACC reads result as registered at the start edge.

## Configuration
- ALU_MUL_EN defined: MUL is implemented as above.
- ALU_MUL_EN undefined: opcode 100 is treated as illegal (single cycle, result unchanged, error=1), and no multiplier datapath or iteration counter is synthesised.

## Structure
- Package alu_seq_pkg holds:
  - op_t enum (ADD..ILLEGAL);
  - state_t enum (IDLE, EXEC, DONE);
  - SEG_DIGIT[0:9] and SEG_ERR/SEG_MINUS constants.
- Sub-module seg7_signed_dec: combinational (value, error) → seg decoder, parametrised by NBITS.

## Test plan
- NBITS=4; start ADD a=3, b=2 → result=5, error=0, seg=0x6D, done one cycle after the start edge +1.
- ADD a=7, b=1 → result=4'b1000, error=1, seg=0x80.
- MUL a=−2, b=3 (ALU_MUL_EN defined) → busy=1 for 4 cycles, then result=−6, seg=0xFD, error=0.
  - Same stimulus with ALU_MUL_EN undefined → error=1, result unchanged.
- CLR, then ACC a=3 twice → result 3, then 6.
  - Third ACC → result=4'b1001, error=1, seg=0x80.
- Assert reset during cycle 2 of MUL → next cycle IDLE, result=0, seg=0x3F.
  - start held high during busy → no second operation.
- op=111 → error=1, result unchanged; following SUB a=−4, b=0 → error=0, seg=0xE6.
